// File: rtl/alien_pkg.sv
// Shared geometry, widths, score table and state encoding for the alien matrix tracker.
package alien_pkg;

    localparam int unsigned ALIEN_ROWS    = 4;
    localparam int unsigned ALIEN_COLUMNS = 8;
    localparam int unsigned CELL_W_LOG2   = 6;
    localparam int unsigned CELL_H_LOG2   = 5;
    localparam int unsigned REFILL_FRAMES = 60;

    localparam int unsigned ALIEN_COUNT = ALIEN_ROWS * ALIEN_COLUMNS;
    localparam int unsigned OFFSET_W    = 11;
    localparam int unsigned COL_W       = $clog2(ALIEN_COLUMNS);
    localparam int unsigned ROW_W       = $clog2(ALIEN_ROWS);
    localparam int unsigned IDX_W       = ROW_W + COL_W;
    localparam int unsigned COUNT_W     = $clog2(ALIEN_COUNT + 1);
    localparam int unsigned FRAME_W     = $clog2(REFILL_FRAMES);
    localparam int unsigned SCORE_W     = 8;

    localparam logic [SCORE_W-1:0] ROW_SCORE [ALIEN_ROWS] = '{8'd30, 8'd20, 8'd10, 8'd10};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WAIT = 2'd2
    } alien_state_t;

endpackage

// File: rtl/alien_column_extent.sv
// Leftmost and rightmost columns that still hold a live alien.
module alien_column_extent
    import alien_pkg::*;
(
    input  logic [ALIEN_COUNT-1:0] aliveMask,
    output logic [COL_W-1:0]       leftColumn,
    output logic [COL_W-1:0]       rightColumn
);

    logic [ALIEN_COLUMNS-1:0] col_any;

    always_comb begin
        col_any = '0;
        for (int r = 0; r < int'(ALIEN_ROWS); r++) begin
            for (int c = 0; c < int'(ALIEN_COLUMNS); c++) begin
                col_any[c] = col_any[c] | aliveMask[r*int'(ALIEN_COLUMNS) + c];
            end
        end
    end

    // Scan direction sets priority; an empty mask leaves the full-width defaults.
    always_comb begin
        leftColumn  = '0;
        rightColumn = COL_W'(ALIEN_COLUMNS - 1);
        for (int c = int'(ALIEN_COLUMNS) - 1; c >= 0; c--) begin
            if (col_any[c]) leftColumn = COL_W'(c);
        end
        for (int c = 0; c < int'(ALIEN_COLUMNS); c++) begin
            if (col_any[c]) rightColumn = COL_W'(c);
        end
    end

endmodule

// File: rtl/alien_matrix_alive_tracker.sv
// Alive-mask bookkeeping for the invader matrix: applies bullet hits, awards score,
// signals defeat and refills the matrix after a fixed number of frames.
module alien_matrix_alive_tracker
    import alien_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic                       playGame,
    input  logic                       bulletHit,
    input  logic signed [OFFSET_W-1:0] hitOffsetX,
    input  logic signed [OFFSET_W-1:0] hitOffsetY,
    output logic [ALIEN_COUNT-1:0]     aliveMask,
    output logic [COUNT_W-1:0]         aliensLeft,
    output logic [COL_W-1:0]           leftColumn,
    output logic [COL_W-1:0]           rightColumn,
    output logic [SCORE_W-1:0]         scoreAdd,
    output logic                       scoreValid,
    output logic                       matrixDefeated
);

    alien_state_t               state;
    logic [FRAME_W-1:0]         frame_cnt;
    logic signed [OFFSET_W-1:0] col_s;
    logic signed [OFFSET_W-1:0] row_s;
    logic                       col_ok;
    logic                       row_ok;
    logic [IDX_W-1:0]           hit_idx;
    logic                       hit_ok;

    // Cell decode: any set bit above the index field means negative or off the matrix.
    assign col_s   = hitOffsetX >>> CELL_W_LOG2;
    assign row_s   = hitOffsetY >>> CELL_H_LOG2;
    assign col_ok  = (col_s[OFFSET_W-1:COL_W] == '0);
    assign row_ok  = (row_s[OFFSET_W-1:ROW_W] == '0);
    assign hit_idx = {row_s[ROW_W-1:0], col_s[COL_W-1:0]};
    assign hit_ok  = bulletHit && (state == PLAY) && col_ok && row_ok && aliveMask[hit_idx];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= IDLE;
            aliveMask      <= '1;
            aliensLeft     <= COUNT_W'(ALIEN_COUNT);
            frame_cnt      <= '0;
            scoreAdd       <= '0;
            scoreValid     <= 1'b0;
            matrixDefeated <= 1'b0;
        end else begin
            scoreValid     <= 1'b0;
            matrixDefeated <= 1'b0;
            if (!playGame) begin
                state      <= IDLE;
                aliveMask  <= '1;
                aliensLeft <= COUNT_W'(ALIEN_COUNT);
                frame_cnt  <= '0;
            end else begin
                unique case (state)
                    IDLE: state <= PLAY;
                    PLAY: begin
                        if (hit_ok) begin
                            aliveMask[hit_idx] <= 1'b0;
                            aliensLeft         <= aliensLeft - COUNT_W'(1);
                            scoreValid         <= 1'b1;
                            scoreAdd           <= ROW_SCORE[row_s[ROW_W-1:0]];
                            if (aliensLeft == COUNT_W'(1)) begin
                                matrixDefeated <= 1'b1;
                                state          <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (startOfFrame) begin
                            if (frame_cnt == FRAME_W'(REFILL_FRAMES - 1)) begin
                                frame_cnt  <= '0;
                                aliveMask  <= '1;
                                aliensLeft <= COUNT_W'(ALIEN_COUNT);
                                state      <= PLAY;
                            end else begin
                                frame_cnt <= frame_cnt + FRAME_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    alien_column_extent u_extent (
        .aliveMask   (aliveMask),
        .leftColumn  (leftColumn),
        .rightColumn (rightColumn)
    );

endmodule
